// File: rtl/debounce_pkg.sv
// Shared constants and helper functions for the multi-channel input debouncer.
package debounce_pkg;

   localparam int DEF_CHANNELS    = 1;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_WIDTH   = 7;
   localparam int DEF_PRESCALE    = 1;

   // Terminal count of a stability counter of the given width.
   function automatic int cnt_max(input int width);
      return (1 << width) - 1;
   endfunction

   // Width of the shared prescaler; never narrower than one bit.
   function automatic int presc_width(input int prescale);
      return (prescale <= 2) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter, registered level, edge pulses and busy.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter logic RST_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic din_i,
   output logic dout_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   dout_q, dout_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   busy_q, busy_d;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      // A toggle needs a mismatch that is still present at the terminal count.
      if (s == dout_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CNT_MAX) begin
            dout_d = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VALUE}};
         cnt_q  <= '0;
         dout_q <= RST_VALUE;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         busy_q <= busy_d;
      end
   end

   assign dout_o = dout_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/debounce_sync_array.sv
// Array of independent debounced input channels sharing one count-enable tick.
// Optional shared prescaler enabled by defining DEBOUNCE_PRESCALER_EN.
module debounce_sync_array
   import debounce_pkg::*;
#(
   parameter int   CHANNELS    = DEF_CHANNELS,
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter logic RST_VALUE   = 1'b0,
   parameter int   PRESCALE    = DEF_PRESCALE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] busy
);

   logic tick;

`ifdef DEBOUNCE_PRESCALER_EN
   localparam int PW = presc_width(PRESCALE);

   logic [PW-1:0] presc_q, presc_d;

   assign tick = (presc_q == PW'(PRESCALE - 1));

   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_WIDTH   (CNT_WIDTH),
         .RST_VALUE   (RST_VALUE)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .tick_i (tick),
         .din_i  (din[g]),
         .dout_o (dout[g]),
         .rise_o (rise[g]),
         .fall_o (fall[g]),
         .busy_o (busy[g])
      );
   end

endmodule

// File: tb/tb_debounce_sync_array.sv
// Directed self-checking bench for the debouncer array (4 channels, 2 sync stages, 3-bit counters).
module tb_debounce_sync_array;

`ifdef DEBOUNCE_PRESCALER_EN
   localparam int TB_PRESCALE = 4;
`else
   localparam int TB_PRESCALE = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'h0;
   logic [3:0] dout, rise, fall, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debounce_sync_array #(
      .CHANNELS    (4),
      .SYNC_STAGES (2),
      .CNT_WIDTH   (3),
      .RST_VALUE   (1'b0),
      .PRESCALE    (TB_PRESCALE)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .dout (dout),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   // Advance n rising edges; outputs are sampled 1 time unit after each edge.
   task automatic edge_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din = 4'h0;
      edge_n(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din = 4'hF;
      for (int i = 0; i < 2; i++) begin
         edge_n(1);
         checks++;
         if ({dout, rise, fall, busy} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs edge %0d: got dout=%h rise=%h fall=%h busy=%h, want all 0",
                     i, dout, rise, fall, busy);
         end
      end
      do_reset();
   endtask

   task automatic test_rise_latency();
      logic [3:0] exp;
      din[0] = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         edge_n(1);
         exp = {(i >= 10), (i == 10), (i >= 3 && i <= 9), 1'b0};
         checks++;
         if ({dout[0], rise[0], busy[0], fall[0]} !== exp) begin
            errors++;
            $display("FAIL rise_latency k+%0d: got dout/rise/busy/fall=%b, want %b",
                     i, {dout[0], rise[0], busy[0], fall[0]}, exp);
         end
      end
   endtask

   task automatic test_glitch();
      din[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) din[1] = 1'b0;
         edge_n(1);
         checks++;
         if (dout[1] !== 1'b0 || rise[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_hold edge %0d: got dout1=%b rise1=%b, want 0 0", i, dout[1], rise[1]);
         end
      end
      din[1] = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         edge_n(1);
         checks++;
         if ({dout[1], rise[1]} !== {(i >= 10), (i == 10)}) begin
            errors++;
            $display("FAIL glitch_retoggle k+%0d: got dout1/rise1=%b, want %b",
                     i, {dout[1], rise[1]}, {(i >= 10), (i == 10)});
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      din = 4'hF;
      edge_n(9);
      checks++;
      if (dout !== 4'h0 || rise !== 4'h0) begin
         errors++;
         $display("FAIL simul_early: got dout=%h rise=%h, want 0 0", dout, rise);
      end
      edge_n(1);
      checks++;
      if (dout !== 4'hF || rise !== 4'hF || fall !== 4'h0 || busy !== 4'h0) begin
         errors++;
         $display("FAIL simul_rise: got dout=%h rise=%h fall=%h busy=%h, want F F 0 0",
                  dout, rise, fall, busy);
      end
      edge_n(1);
      checks++;
      if (rise !== 4'h0 || dout !== 4'hF) begin
         errors++;
         $display("FAIL simul_pulse_end: got rise=%h dout=%h, want 0 F", rise, dout);
      end
      din[2] = 1'b0;
      edge_n(9);
      checks++;
      if (dout !== 4'hF || fall !== 4'h0) begin
         errors++;
         $display("FAIL fall_early: got dout=%h fall=%h, want F 0", dout, fall);
      end
      edge_n(1);
      checks++;
      if (fall !== 4'h4 || rise !== 4'h0 || dout !== 4'hB) begin
         errors++;
         $display("FAIL fall_single: got fall=%h rise=%h dout=%h, want 4 0 B", fall, rise, dout);
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      din[3] = 1'b1;
      edge_n(7);
      checks++;
      if (busy[3] !== 1'b1 || dout[3] !== 1'b0) begin
         errors++;
         $display("FAIL abort_precount: got busy3=%b dout3=%b, want 1 0", busy[3], dout[3]);
      end
      rst = 1'b1;
      edge_n(1);
      checks++;
      if (dout !== 4'h0 || busy !== 4'h0 || rise !== 4'h0) begin
         errors++;
         $display("FAIL abort_cleared: got dout=%h busy=%h rise=%h, want 0 0 0", dout, busy, rise);
      end
      rst = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         edge_n(1);
         checks++;
         if ({dout[3], rise[3]} !== {(i >= 10), (i == 10)}) begin
            errors++;
            $display("FAIL abort_restart k+%0d: got dout3/rise3=%b, want %b",
                     i, {dout[3], rise[3]}, {(i >= 10), (i == 10)});
         end
      end
   endtask

   task automatic test_prescale();
      int n;
      do_reset();
      din[0] = 1'b1;
      n = 0;
      while (n < 60) begin
         edge_n(1);
         n++;
         if (dout[0] === 1'b1) break;
      end
      checks++;
      if (!(n >= 31 && n <= 34) || rise[0] !== 1'b1) begin
         errors++;
         $display("FAIL prescale_latency: got %0d edges rise0=%b, want 31..34 and 1", n, rise[0]);
      end
   endtask

   initial begin
      test_reset();
`ifdef DEBOUNCE_PRESCALER_EN
      test_prescale();
`else
      test_rise_latency();
      test_glitch();
      test_simultaneous();
      test_reset_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
